// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse symbol player: segment codes,
// packed Morse code descriptor and the playback FSM state encoding.
package morse_pkg;

  localparam logic [6:0] SEG_DOT   = 7'b1001000;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam int MORSE_MAX_LEN = 5;

  // pat is MSB-first: element k lives in pat[4-k]; a 1 bit is a dash
  typedef struct packed {
    logic [2:0] len;
    logic [4:0] pat;
  } morse_code_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } morse_state_t;

  function automatic logic [6:0] seg_of(input logic dash);
    return dash ? SEG_DASH : SEG_DOT;
  endfunction

endpackage

// File: rtl/morse_code_rom.sv
// Combinational lookup from a hex symbol to its Morse length and pattern.
module morse_code_rom
  import morse_pkg::*;
(
  input  logic [3:0]  symbol,
  output morse_code_t code
);

  always_comb begin
    code = '{len: 3'd5, pat: 5'b11111};
    case (symbol)
      4'h0: code = '{len: 3'd5, pat: 5'b11111};
      4'h1: code = '{len: 3'd5, pat: 5'b01111};
      4'h2: code = '{len: 3'd5, pat: 5'b00111};
      4'h3: code = '{len: 3'd5, pat: 5'b00011};
      4'h4: code = '{len: 3'd5, pat: 5'b00001};
      4'h5: code = '{len: 3'd5, pat: 5'b00000};
      4'h6: code = '{len: 3'd5, pat: 5'b10000};
      4'h7: code = '{len: 3'd5, pat: 5'b11000};
      4'h8: code = '{len: 3'd5, pat: 5'b11100};
      4'h9: code = '{len: 3'd5, pat: 5'b11110};
      4'hA: code = '{len: 3'd2, pat: 5'b01000};
      4'hB: code = '{len: 3'd4, pat: 5'b10000};
      4'hC: code = '{len: 3'd4, pat: 5'b10100};
      4'hD: code = '{len: 3'd3, pat: 5'b10000};
      4'hE: code = '{len: 3'd1, pat: 5'b00000};
      4'hF: code = '{len: 3'd4, pat: 5'b00100};
      default: code = '{len: 3'd5, pat: 5'b11111};
    endcase
  end

endmodule

// File: rtl/morse_symbol_player.sv
// Morse symbol player: shows a symbol's pattern statically on seven-segment
// digits, or plays it as timed LED blinks while revealing digits one by one.
module morse_symbol_player
  import morse_pkg::*;
#(
  parameter int NUM_DIGITS  = 5,
  parameter int UNIT_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              symbol,
  input  logic                    start,
  input  logic                    mode,
  input  logic                    clear,
  output logic [NUM_DIGITS*7-1:0] display,
  output logic                    led,
  output logic                    busy,
  output logic                    done,
  output morse_state_t            state_dbg
);

  localparam int CW = $clog2(3 * UNIT_CYCLES);
  localparam logic [CW-1:0] DOT_LAST  = CW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] DASH_LAST = CW'(3 * UNIT_CYCLES - 1);
  localparam logic [NUM_DIGITS*7-1:0] ALL_BLANK = {NUM_DIGITS{SEG_BLANK}};

  morse_state_t            state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [2:0]              idx_q, idx_d;
  morse_code_t             code_q, code_d, rom_code;
  logic [NUM_DIGITS*7-1:0] disp_q, disp_d, full_disp;
  logic                    led_q, busy_q, done_q, done_d;
  logic                    accept;
  logic [CW-1:0]           elem_last;

  morse_code_rom u_rom (
    .symbol (symbol),
    .code   (rom_code)
  );

  // Paint element k of code onto its right-aligned digit position.
  function automatic logic [NUM_DIGITS*7-1:0] reveal(
    input logic [NUM_DIGITS*7-1:0] base,
    input morse_code_t             code,
    input logic [2:0]              k
  );
    logic [2:0] bit_sel;
    int         pos;
    bit_sel = 3'd4 - k;
    pos     = NUM_DIGITS - int'(code.len) + int'(k);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i == pos) base[i*7 +: 7] = seg_of(code.pat[bit_sel]);
    end
    return base;
  endfunction

  always_comb begin
    full_disp = ALL_BLANK;
    for (int k = 0; k < MORSE_MAX_LEN; k++) begin
      if (k < int'(rom_code.len)) full_disp = reveal(full_disp, rom_code, 3'(k));
    end
  end

  // start is a request qualified by !busy: it is taken on any edge where the
  // FSM is IDLE or FIN (busy low), otherwise dropped without effect.
  assign accept    = start && ((state_q == IDLE) || (state_q == FIN));
  assign elem_last = code_q.pat[3'd4 - idx_q] ? DASH_LAST : DOT_LAST;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    code_d  = code_q;
    disp_d  = disp_q;
    done_d  = 1'b0;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      disp_d  = ALL_BLANK;
    end else begin
      case (state_q)
        IDLE, FIN: begin
          state_d = IDLE;
          if (accept) begin
            code_d = rom_code;
            cnt_d  = '0;
            idx_d  = '0;
            if (mode) begin
              state_d = ON;
              disp_d  = reveal(ALL_BLANK, rom_code, 3'd0);
            end else begin
              disp_d = full_disp;
              done_d = 1'b1;
            end
          end
        end
        ON: begin
          if (cnt_q == elem_last) begin
            cnt_d = '0;
            if (idx_q == code_q.len - 3'd1) begin
              state_d = FIN;
              done_d  = 1'b1;
            end else begin
              state_d = GAP;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        GAP: begin
          if (cnt_q == DOT_LAST) begin
            cnt_d   = '0;
            idx_d   = idx_q + 3'd1;
            state_d = ON;
            disp_d  = reveal(disp_q, code_q, idx_q + 3'd1);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      code_q  <= '0;
      disp_q  <= ALL_BLANK;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      disp_q  <= disp_d;
      led_q   <= (state_d == ON);
      busy_q  <= (state_d == ON) || (state_d == GAP);
      done_q  <= done_d;
    end
  end

  assign display   = disp_q;
  assign led       = led_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_morse_symbol_player.sv
// Self-checking bench for morse_symbol_player: two instances (unit 4 and 2)
// compared every cycle against per-cycle expectations queued by a Morse model.
module tb_morse_symbol_player;
  import morse_pkg::*;

  localparam int ND = 5;
  localparam int W  = ND * 7 + 3;
  localparam logic [W-1:0] ALL_BLANK = {{ND{SEG_BLANK}}, 3'b000};

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start4, start2, mode, clear;
  logic [3:0]   symbol;
  logic [ND*7-1:0] display4, display2;
  logic         led4, busy4, done4, led2, busy2, done2;
  morse_state_t st4, st2;

  morse_symbol_player #(.NUM_DIGITS(ND), .UNIT_CYCLES(4)) u_dut4 (
    .clk(clk), .rst(rst), .symbol(symbol), .start(start4), .mode(mode),
    .clear(clear), .display(display4), .led(led4), .busy(busy4),
    .done(done4), .state_dbg(st4)
  );

  morse_symbol_player #(.NUM_DIGITS(ND), .UNIT_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .symbol(symbol), .start(start2), .mode(mode),
    .clear(clear), .display(display2), .led(led2), .busy(busy2),
    .done(done2), .state_dbg(st2)
  );

  // scoreboard: {display, led, busy, done} per cycle
  logic [W-1:0] exp4_q[$];
  logic [W-1:0] exp2_q[$];
  logic [W-1:0] hold4, hold2;
  bit           mon_en = 1'b0;
  int           checks = 0;
  int           errors = 0;

  string morse_tbl[16] = '{
    "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
    "---..", "----.", ".-", "-...", "-.-.", "-..", ".", "..-."
  };

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [ND*7-1:0] set_digit(input logic [ND*7-1:0] d, input int pos,
                                                input logic [6:0] seg);
    d[pos*7 +: 7] = seg;
    return d;
  endfunction

  task automatic push_exp(input int which, input logic [W-1:0] v);
    if (which == 0) exp4_q.push_back(v);
    else exp2_q.push_back(v);
  endtask

  task automatic push_model(input int which, input logic [3:0] sym, input logic md);
    string           s;
    int              len, u;
    logic [ND*7-1:0] d;
    logic [6:0]      seg;
    bit              dash;
    s   = morse_tbl[sym];
    len = s.len();
    u   = (which == 0) ? 4 : 2;
    d   = {ND{SEG_BLANK}};
    for (int k = 0; k < len; k++) begin
      dash = (s.getc(k) == "-");
      seg  = dash ? SEG_DASH : SEG_DOT;
      d    = set_digit(d, ND - len + k, seg);
      if (md) begin
        repeat (dash ? 3 * u : u) push_exp(which, {d, 3'b110});
        if (k < len - 1) repeat (u) push_exp(which, {d, 3'b010});
      end
    end
    push_exp(which, {d, 3'b001});
  endtask

  task automatic flush_all();
    exp4_q.delete();
    exp2_q.delete();
    hold4 = ALL_BLANK;
    hold2 = ALL_BLANK;
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (mon_en) begin
      if (exp4_q.size() > 0) begin
        e = exp4_q.pop_front();
        hold4 = {e[W-1:3], 3'b000};
      end else begin
        e = hold4;
      end
      check_eq("dut4_out", 64'({display4, led4, busy4, done4}), 64'(e));
    end
  end

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (mon_en) begin
      if (exp2_q.size() > 0) begin
        e = exp2_q.pop_front();
        hold2 = {e[W-1:3], 3'b000};
      end else begin
        e = hold2;
      end
      check_eq("dut2_out", 64'({display2, led2, busy2, done2}), 64'(e));
    end
  end

  // driver tasks: all begin and end just after a rising edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input int which, input logic [3:0] sym, input logic md);
    symbol = sym;
    mode   = md;
    if (which == 0) start4 = 1'b1;
    else start2 = 1'b1;
    tick(1);
    start4 = 1'b0;
    start2 = 1'b0;
    push_model(which, sym, md);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    flush_all();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(1);
    flush_all();
    tick(1);
    rst = 1'b1;
  endtask

  task automatic wait_idle(input int which);
    for (int i = 0; i < 300; i++) begin
      if (which == 0 && exp4_q.size() == 0) return;
      if (which == 1 && exp2_q.size() == 0) return;
      tick(1);
    end
    check_eq("wait_idle_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    rst    = 1'b0;
    start4 = 1'b0;
    start2 = 1'b0;
    mode   = 1'b0;
    clear  = 1'b0;
    symbol = 4'h0;
    hold4  = ALL_BLANK;
    hold2  = ALL_BLANK;
    tick(1);
    mon_en = 1'b1;
    tick(1);
    rst = 1'b1;
    check_eq("reset_state4", 64'(st4), 64'(IDLE));

    // static A, playback E (unit 4), playback 0 (unit 2)
    do_start(0, 4'hA, 1'b0);
    wait_idle(0);
    do_start(0, 4'hE, 1'b1);
    wait_idle(0);
    do_start(1, 4'h0, 1'b1);
    wait_idle(1);

    // new request in the done cycle is accepted immediately
    do_start(1, 4'hE, 1'b1);
    tick(2);
    do_start(1, 4'hA, 1'b1);
    wait_idle(1);

    // start with a new symbol while busy is ignored
    do_start(0, 4'h3, 1'b1);
    tick(5);
    symbol = 4'h0;
    mode   = 1'b0;
    start4 = 1'b1;
    tick(1);
    start4 = 1'b0;
    wait_idle(0);

    // abort of B after 10 cycles; no done may follow
    do_start(0, 4'hB, 1'b1);
    tick(9);
    do_clear();
    tick(30);
    check_eq("abort_state4", 64'(st4), 64'(IDLE));

    // start and clear together from idle: clear wins
    symbol = 4'h7;
    mode   = 1'b0;
    start4 = 1'b1;
    start2 = 1'b1;
    clear  = 1'b1;
    tick(1);
    start4 = 1'b0;
    start2 = 1'b0;
    clear  = 1'b0;
    flush_all();
    tick(5);

    // reset held two cycles mid-playback
    do_start(1, 4'h9, 1'b1);
    tick(7);
    do_reset();
    tick(3);
    check_eq("reset_state2", 64'(st2), 64'(IDLE));

    // random symbols and modes on both instances
    repeat (6) begin
      do_start(1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      wait_idle(1);
      do_start(0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      wait_idle(0);
    end
    tick(3);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
